// File: rtl/watchdog_timer.sv
// Supervisory watchdog: counts enabled cycles, warns early, trips and pulses force_reset on timeout.
// Define WD_FORMAL_EN to compile in the internal formal properties and cover.
module watchdog_timer #(
    parameter int unsigned TIMEOUT_CYCLES     = 1000000,
    parameter int unsigned WARNING_CYCLES     = 750000,
    parameter int unsigned RESET_PULSE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        heartbeat,
    output logic        force_reset,
    output logic        warning,
    output logic        triggered,
    output logic [31:0] count
);

    localparam int unsigned     PW         = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
    localparam logic [31:0]     COUNT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     WARN_AT    = 32'(WARNING_CYCLES);
    localparam logic [PW-1:0]   PULSE_LOAD = PW'(RESET_PULSE_CYCLES - 1);

    logic [PW-1:0] pulse_cnt;
    logic [31:0]   count_next;
    logic          kick;
    logic          trip_now;

    assign count_next = count + 32'd1;
    assign kick       = !enable || heartbeat;
    // A kick in the timeout cycle wins, so the trip needs a clean enabled, un-kicked cycle.
    assign trip_now   = !kick && !triggered && (count == COUNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            warning     <= 1'b0;
            triggered   <= 1'b0;
            force_reset <= 1'b0;
            pulse_cnt   <= '0;
        end else begin
            if (kick) begin
                count   <= '0;
                warning <= 1'b0;
            end else if (trip_now) begin
                triggered <= 1'b1;
                count     <= '0;
                warning   <= 1'b0;
            end else if (!triggered) begin
                count   <= count_next;
                warning <= (count_next >= WARN_AT);
            end else begin
                count <= '0;
            end

            // The pulse runs independently of enable/heartbeat once started.
            if (trip_now) begin
                force_reset <= 1'b1;
                pulse_cnt   <= PULSE_LOAD;
            end else if (force_reset) begin
                if (pulse_cnt == '0) begin
                    force_reset <= 1'b0;
                end else begin
                    pulse_cnt <= pulse_cnt - PW'(1);
                end
            end
        end
    end

`ifdef WD_FORMAL_EN
    logic f_past_valid;

    // Properties only hold once a reset has defined the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_past_valid <= 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clk) f_past_valid |-> (count <= COUNT_LAST));
    a_pulse_needs_trip: assert property (@(posedge clk) f_past_valid |-> (!force_reset || triggered));
    a_trip_sticky: assert property (@(posedge clk) (f_past_valid && triggered && !rst) |=> triggered);
    a_warn_low: assert property (@(posedge clk) (f_past_valid && (count < WARN_AT)) |-> !warning);
    c_trip_from_reset: cover property (@(posedge clk)
        rst ##1 (!rst && !heartbeat)[*1:$] ##0 $rose(force_reset));
`endif

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed bench for watchdog_timer with TIMEOUT=4, WARNING=2, PULSE=3.
module tb_watchdog_timer;

    localparam int unsigned TO = 4;
    localparam int unsigned WN = 2;
    localparam int unsigned RP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        heartbeat;
    logic        force_reset;
    logic        warning;
    logic        triggered;
    logic [31:0] count;
    logic [34:0] obs;

    int vectors     = 0;
    int miscompares = 0;

    watchdog_timer #(
        .TIMEOUT_CYCLES    (TO),
        .WARNING_CYCLES    (WN),
        .RESET_PULSE_CYCLES(RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .heartbeat  (heartbeat),
        .force_reset(force_reset),
        .warning    (warning),
        .triggered  (triggered),
        .count      (count)
    );

    // Packed observation: {force_reset, triggered, warning, count}
    assign obs = {force_reset, triggered, warning, count};

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        heartbeat = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        heartbeat = 1'b1;
        tick();
        tick();
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got fr=%b trig=%b warn=%b cnt=%0d, expected all 0",
                     force_reset, triggered, warning, count);
        end
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        logic [34:0] exp_v [8];
        exp_v = '{{1'b0, 1'b0, 1'b0, 32'd1},
                  {1'b0, 1'b0, 1'b1, 32'd2},
                  {1'b0, 1'b0, 1'b1, 32'd3},
                  {1'b1, 1'b1, 1'b0, 32'd0},
                  {1'b1, 1'b1, 1'b0, 32'd0},
                  {1'b1, 1'b1, 1'b0, 32'd0},
                  {1'b0, 1'b1, 1'b0, 32'd0},
                  {1'b0, 1'b1, 1'b0, 32'd0}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (obs !== exp_v[i]) begin
                miscompares++;
                $display("FAIL timeout_edge%0d: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=%b trig=%b warn=%b cnt=%0d",
                         i + 1, obs[34], obs[33], obs[32], obs[31:0],
                         exp_v[i][34], exp_v[i][33], exp_v[i][32], exp_v[i][31:0]);
            end
        end
    endtask

    task automatic test_periodic_kick();
        logic [31:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            heartbeat = (i % 3 == 2);
            // Kick every third cycle: count runs 1,2 then clears.
            exp_cnt = heartbeat ? 32'd0 : 32'(i % 3 + 1);
            tick();
            vectors++;
            if (obs !== {1'b0, 1'b0, (exp_cnt >= 32'(WN)), exp_cnt}) begin
                miscompares++;
                $display("FAIL kick_cycle%0d: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=0 trig=0 warn=%b cnt=%0d",
                         i, force_reset, triggered, warning, count, (exp_cnt >= 32'(WN)), exp_cnt);
            end
        end
        heartbeat = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        tick();
        tick();
        vectors++;
        if (count !== 32'd3) begin
            miscompares++;
            $display("FAIL simul_precount: got cnt=%0d, expected 3", count);
        end
        heartbeat = 1'b1;
        tick();
        heartbeat = 1'b0;
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL simul_kick_wins: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=0 trig=0 warn=0 cnt=0",
                     force_reset, triggered, warning, count);
        end
        tick();
        tick();
        tick();
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b1, 32'd3}) begin
            miscompares++;
            $display("FAIL simul_edge3: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=0 trig=0 warn=1 cnt=3",
                     force_reset, triggered, warning, count);
        end
        tick();
        vectors++;
        if (obs !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL simul_retrip: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=1 trig=1 warn=0 cnt=0",
                     force_reset, triggered, warning, count);
        end
    endtask

    task automatic test_disable();
        do_reset();
        tick();
        tick();
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b1, 32'd2}) begin
            miscompares++;
            $display("FAIL disable_precount: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=0 trig=0 warn=1 cnt=2",
                     force_reset, triggered, warning, count);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (obs !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
                miscompares++;
                $display("FAIL disable_cycle%0d: got fr=%b trig=%b warn=%b cnt=%0d, expected all 0",
                         i, force_reset, triggered, warning, count);
            end
        end
        enable = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if (triggered !== 1'b0) begin
            miscompares++;
            $display("FAIL reenable_early: got trig=%b, expected 0", triggered);
        end
        tick();
        vectors++;
        if (obs !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reenable_trip: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=1 trig=1 warn=0 cnt=0",
                     force_reset, triggered, warning, count);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        repeat (TO) tick();
        tick();
        vectors++;
        if ({force_reset, triggered} !== 2'b11) begin
            miscompares++;
            $display("FAIL midpulse_second: got fr=%b trig=%b, expected fr=1 trig=1", force_reset, triggered);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL midpulse_reset: got fr=%b trig=%b warn=%b cnt=%0d, expected all 0",
                     force_reset, triggered, warning, count);
        end
        tick();
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'd1}) begin
            miscompares++;
            $display("FAIL midpulse_restart: got fr=%b trig=%b warn=%b cnt=%0d, expected fr=0 trig=0 warn=0 cnt=1",
                     force_reset, triggered, warning, count);
        end
        // After reset the pulse must be fully re-armed: a new trip gives a full-width pulse.
        repeat (TO - 1) tick();
        vectors++;
        if ({force_reset, triggered} !== 2'b11) begin
            miscompares++;
            $display("FAIL midpulse_retrip: got fr=%b trig=%b, expected fr=1 trig=1", force_reset, triggered);
        end
    endtask

    task automatic test_sticky();
        int high_cycles;
        int rises;
        logic prev_fr;
        do_reset();
        repeat (TO) tick();
        high_cycles = force_reset ? 1 : 0;
        rises       = force_reset ? 1 : 0;
        prev_fr     = force_reset;
        for (int i = 0; i < 20; i++) begin
            heartbeat = (i % 2 == 0);
            tick();
            if (force_reset) high_cycles++;
            if (force_reset && !prev_fr) rises++;
            prev_fr = force_reset;
            vectors++;
            if ({triggered, warning, count} !== {1'b1, 1'b0, 32'd0}) begin
                miscompares++;
                $display("FAIL sticky_cycle%0d: got trig=%b warn=%b cnt=%0d, expected trig=1 warn=0 cnt=0",
                         i, triggered, warning, count);
            end
        end
        heartbeat = 1'b0;
        vectors++;
        if (high_cycles != int'(RP)) begin
            miscompares++;
            $display("FAIL sticky_pulse_width: got %0d cycles, expected %0d", high_cycles, RP);
        end
        vectors++;
        if (rises != 1) begin
            miscompares++;
            $display("FAIL sticky_pulse_count: got %0d pulses, expected 1", rises);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        heartbeat = 1'b0;
        test_reset();
        test_timeout();
        test_periodic_kick();
        test_simultaneous();
        test_disable();
        test_reset_mid_pulse();
        test_sticky();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/watchdog_timer.md
Name: watchdog_timer

Overview:
- Supervisory timer that counts clock cycles while enabled.
- Raises an early `warning` when software is slow to service it.
- If no `heartbeat` arrives within the timeout window, latches a trip and drives a fixed-width `force_reset` pulse to the system reset controller.
- Sits beside the control CPU/sequencer; `heartbeat` is the software kick.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles without heartbeat before trip; legal range 2..2^32-1.
- WARNING_CYCLES, 750000, count at which `warning` asserts; must be less than TIMEOUT_CYCLES.
- RESET_PULSE_CYCLES, 16, width in cycles of the `force_reset` pulse; at least 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  watchdog counting enable.
- heartbeat  input  1  kick from software; level-sampled each cycle.
- force_reset  output  1  registered reset-request pulse.
- warning  output  1  registered early-warning flag.
- triggered  output  1  sticky trip flag.
- count  output  32  current counter value, for status readback.

Behaviour:
- Reset (`rst`=1 at a clock edge): count=0, warning=0, triggered=0, force_reset=0, pulse counter=0. Reset has priority over all inputs.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Per-cycle priority when `rst`=0:
  1. enable=0: count<=0 and warning<=0. triggered and the force_reset pulse continue unaffected.
  2. Otherwise, heartbeat=1: count<=0 and warning<=0. A heartbeat does not clear triggered and does not stop a running pulse.
  3. Otherwise, triggered=0 and count==TIMEOUT_CYCLES-1: triggered<=1, count<=0, force_reset<=1, pulse counter loads RESET_PULSE_CYCLES-1.
  4. Otherwise, triggered=0: count<=count+1, and warning<=1 when count+1 >= WARNING_CYCLES.
  5. Otherwise (triggered=1): count holds at 0.
- Trip latency:
  - With enable=1 and heartbeat=0 continuously from a count of 0, force_reset and triggered first read 1 exactly TIMEOUT_CYCLES edges later.
  - Example: TIMEOUT_CYCLES=4 gives count 1,2,3, then the trip on the 4th edge.
- Pulse:
  - force_reset stays 1 for exactly RESET_PULSE_CYCLES cycles.
  - The pulse counter decrements each cycle; force_reset<=0 on the edge where the pulse counter is 0.
  - The pulse is one-shot per trip.
- triggered is sticky and is cleared only by rst. While triggered=1, no further trips occur.
- Heartbeat and timeout in the same cycle: the heartbeat wins, count<=0 and no trip.
- Count arithmetic is 32-bit unsigned. The count never exceeds TIMEOUT_CYCLES-1, so there is no wrap.
- warning stays 1 until a heartbeat, enable=0, rst, or a trip. On the trip cycle warning<=0.

Optional Feature:
- Macro: WD_FORMAL_EN.
- When defined, the block compiles in internal formal properties. An `f_past_valid` register gates them, and they are:
  - count <= TIMEOUT_CYCLES-1.
  - force_reset implies triggered.
  - triggered never falls without rst.
  - warning is 0 while count < WARNING_CYCLES.
  - Cover: force_reset rising with heartbeat=0 from reset.
- When undefined, none of this logic exists and the RTL behaviour is identical.

Test Plan:
- Timeout trip (TIMEOUT_CYCLES=4, WARNING_CYCLES=2, RESET_PULSE_CYCLES=3): rst 1 cycle, then enable=1, heartbeat=0.
  - warning=1 after 2 edges.
  - triggered=1 and force_reset=1 after 4 edges.
  - force_reset stays high 3 cycles then 0; triggered stays 1.
- Periodic kick (same parameters): heartbeat=1 every 3rd cycle for 50 cycles → count never exceeds 2, warning toggles, force_reset=0 and triggered=0 throughout.
- Simultaneous events: heartbeat=1 on the cycle count==3 → count=0, no trip. The next trip occurs 4 edges later.
- Disable: enable=0 for 10 cycles mid-count at count=2 → count=0 and warning=0, with no trip. Re-enable gives a trip 4 edges later.
- Reset mid-pulse: assert rst on the 2nd force_reset cycle → next cycle force_reset=0, triggered=0, count=0. Counting restarts after rst deasserts.
- Sticky trip: after a trip, apply heartbeat pulses and hold enable=1 for 20 cycles → triggered stays 1, exactly one force_reset pulse, count=0.
